// File: rtl/aes_round_sequencer.sv
// -----------------------------------------------------------------------------
// aes_round_sequencer
//   Control FSM for the 32-bit GF(2^4) AES round datapath. Takes one 128-bit
//   block as four 32-bit words and runs the initial AddRoundKey (INPUT phase).
//   It then runs NR-1 full rounds (ROUND) and the final round (LAST), and
//   streams the four result words out (DONE). Each phase is four word cycles.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   start          begin a block (sampled only in IDLE)
//   mode_in        1 = encrypt, 0 = decrypt; latched on accepted start
//   abort          synchronous cancel from any state
//   in_valid       input word present on the datapath input bus
//   in_ready       high throughout the INPUT phase
//   key_valid      requested round-key word is stable
//   key_round      round-key index requested from the key schedule
//   key_word       word of that round key (= count_cycle)
//   count_cycle    word position within the current phase
//   mode           latched mode to the datapath
//   input_round    datapath phase strobe
//   last_round     datapath phase strobe
//   done_round     datapath phase strobe
//   idle_round     datapath phase strobe; 1 = datapath register holds
//   out_valid      result word valid (= done_round)
//   busy           high in every state except IDLE
//   done           one-cycle pulse after the fourth output word
// -----------------------------------------------------------------------------
module aes_round_sequencer #(
  parameter int NR     = 10,
  parameter int KIDX_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode_in,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              key_valid,
  output logic [KIDX_W-1:0] key_round,
  output logic [1:0]        key_word,
  output logic [1:0]        count_cycle,
  output logic              mode,
  output logic              input_round,
  output logic              last_round,
  output logic              done_round,
  output logic              idle_round,
  output logic              out_valid,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INPUT = 3'd1,
    S_ROUND = 3'd2,
    S_LAST  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [KIDX_W-1:0]   r_round, w_round_nxt;
  logic [1:0]          r_cc, w_cc_nxt;
  logic                r_mode, w_mode_nxt;
  logic                w_done_nxt;
  logic                w_active;
  logic                w_stall;

  logic                r_in_ready;
  logic                r_input_round;
  logic                r_last_round;
  logic                r_done_round;
  logic                r_busy;
  logic                r_done;
  logic                r_idle_base;
  logic [KIDX_W-1:0]   r_key_round;

  // Encrypt walks the key schedule forwards, decrypt walks it backwards.
  // IDLE and DONE do not consume keys, so the index is parked at 0.
  function automatic logic [KIDX_W-1:0] key_idx(input state_t st,
                                                input logic [KIDX_W-1:0] rnd,
                                                input logic md);
    logic [KIDX_W-1:0] k;
    k = '0;
    if (st == S_INPUT || st == S_ROUND || st == S_LAST)
      k = md ? rnd : (KIDX_W'(NR) - rnd);
    return k;
  endfunction

  assign w_active = (r_state == S_INPUT) || (r_state == S_ROUND) || (r_state == S_LAST);
  // Either a missing key word or (in INPUT) a missing data word freezes the
  // phase for this cycle.
  assign w_stall  = w_active && (!key_valid || ((r_state == S_INPUT) && !in_valid));

  always_comb begin
    w_state_nxt = r_state;
    w_round_nxt = r_round;
    w_cc_nxt    = r_cc;
    w_mode_nxt  = r_mode;
    w_done_nxt  = 1'b0;
    if (abort) begin
      w_state_nxt = S_IDLE;
      w_round_nxt = '0;
      w_cc_nxt    = '0;
      w_mode_nxt  = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          w_round_nxt = '0;
          w_cc_nxt    = '0;
          if (start) begin
            w_state_nxt = S_INPUT;
            w_mode_nxt  = mode_in;
          end
        end
        S_INPUT: begin
          if (!w_stall) begin
            w_cc_nxt = r_cc + 2'd1;
            if (r_cc == 2'd3) begin
              w_state_nxt = S_ROUND;
              w_round_nxt = KIDX_W'(1);
            end
          end
        end
        S_ROUND: begin
          if (!w_stall) begin
            w_cc_nxt = r_cc + 2'd1;
            if (r_cc == 2'd3) begin
              w_round_nxt = r_round + KIDX_W'(1);
              if (r_round == KIDX_W'(NR - 1))
                w_state_nxt = S_LAST;
            end
          end
        end
        S_LAST: begin
          if (!w_stall) begin
            w_cc_nxt = r_cc + 2'd1;
            if (r_cc == 2'd3) begin
              w_state_nxt = S_DONE;
              w_round_nxt = '0;
            end
          end
        end
        S_DONE: begin
          // No backpressure on the output side: one word per cycle.
          w_cc_nxt = r_cc + 2'd1;
          if (r_cc == 2'd3) begin
            w_state_nxt = S_IDLE;
            w_mode_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_round_nxt = '0;
          w_cc_nxt    = '0;
          w_mode_nxt  = 1'b0;
        end
      endcase
    end
  end

  // Outputs are registered from the next-state values so they line up with
  // the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_round       <= '0;
      r_cc          <= '0;
      r_mode        <= 1'b0;
      r_in_ready    <= 1'b0;
      r_input_round <= 1'b0;
      r_last_round  <= 1'b0;
      r_done_round  <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_idle_base   <= 1'b1;
      r_key_round   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_round       <= w_round_nxt;
      r_cc          <= w_cc_nxt;
      r_mode        <= w_mode_nxt;
      r_in_ready    <= (w_state_nxt == S_INPUT);
      r_input_round <= (w_state_nxt == S_INPUT);
      r_last_round  <= (w_state_nxt == S_LAST);
      r_done_round  <= (w_state_nxt == S_DONE);
      r_busy        <= (w_state_nxt != S_IDLE);
      r_done        <= w_done_nxt;
      r_idle_base   <= (w_state_nxt == S_IDLE);
      r_key_round   <= key_idx(w_state_nxt, w_round_nxt, w_mode_nxt);
    end
  end

  assign in_ready    = r_in_ready;
  assign key_round   = r_key_round;
  assign key_word    = r_cc;
  assign count_cycle = r_cc;
  assign mode        = r_mode;
  assign input_round = r_input_round;
  assign last_round  = r_last_round;
  assign done_round  = r_done_round;
  assign out_valid   = r_done_round;
  assign busy        = r_busy;
  assign done        = r_done;
  // A stall must hold the datapath in the very cycle the word or key is
  // missing, so the stall term is OR-ed onto the registered idle strobe.
  assign idle_round  = r_idle_base | w_stall;

endmodule

// File: tb/tb_aes_round_sequencer.sv
module tb_aes_round_sequencer;
  localparam int NR = 10;
  localparam int KW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          mode_in = 1'b0;
  logic          abort = 1'b0;
  logic          in_valid = 1'b0;
  logic          key_valid = 1'b0;
  logic          in_ready;
  logic [KW-1:0] key_round;
  logic [1:0]    key_word;
  logic [1:0]    count_cycle;
  logic          mode;
  logic          input_round;
  logic          last_round;
  logic          done_round;
  logic          idle_round;
  logic          out_valid;
  logic          busy;
  logic          done;

  aes_round_sequencer #(.NR(NR), .KIDX_W(KW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode_in(mode_in), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .key_valid(key_valid),
    .key_round(key_round), .key_word(key_word), .count_cycle(count_cycle),
    .mode(mode), .input_round(input_round), .last_round(last_round),
    .done_round(done_round), .idle_round(idle_round), .out_valid(out_valid),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  wire w_is_round = busy & ~input_round & ~last_round & ~done_round;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_idle_round"}, 32'(idle_round), 32'd1);
    check({tag, "_busy"},       32'(busy),       32'd0);
    check({tag, "_in_ready"},   32'(in_ready),   32'd0);
    check({tag, "_key_round"},  32'(key_round),  32'd0);
    check({tag, "_count"},      32'(count_cycle), 32'd0);
    check({tag, "_mode"},       32'(mode),       32'd0);
    check({tag, "_strobes"},    32'({input_round, last_round, done_round}), 32'd0);
    check({tag, "_out_valid"},  32'(out_valid),  32'd0);
    check({tag, "_done"},       32'(done),       32'd0);
  endtask

  int t0, t_out, t_done, n_done, n_out, n_inr, n_multi, n_idle_busy;
  int keyq[$];

  task automatic run_block(input bit m, input bit stalls, input bit do_abort,
                           input bit do_reset, input bit overlap);
    int  in_drop, key_drop, post, abort_c;
    bit  did_in, did_key, aborted, resetted, finished;
    in_drop = 0; key_drop = 0; post = 0; abort_c = -100;
    did_in = 0; did_key = 0; aborted = 0; resetted = 0; finished = 0;
    t0 = -1; t_out = -1; t_done = -1; n_done = 0; n_out = 0; n_inr = 0;
    n_multi = 0; n_idle_busy = 0;
    keyq.delete();
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      start   = (c == 0) || (overlap && c == 20);
      mode_in = (c == 0) ? m : ~m;
      abort   = 1'b0;
      if (stalls && !did_in && input_round && count_cycle == 2'd2) begin
        in_drop = 3; did_in = 1;
      end
      if (stalls && !did_key && w_is_round && key_round == 4'd5 && count_cycle == 2'd1) begin
        key_drop = 2; did_key = 1;
      end
      in_valid  = (in_drop == 0);
      key_valid = (key_drop == 0);
      if (do_abort && !aborted && w_is_round && key_round == 4'd6 && count_cycle == 2'd2) begin
        abort = 1'b1; aborted = 1; abort_c = c;
      end
      if (do_reset && !resetted && last_round && count_cycle == 2'd1) begin
        rst_n = 1'b0; resetted = 1;
      end
      #1;
      if (resetted) begin
        check_reset_outputs("async_rst");
        finished = 1;
        break;
      end
      if (in_drop > 0) begin
        check("install_idle", 32'(idle_round), 32'd1);
        check("install_cc",   32'(count_cycle), 32'd2);
        in_drop--;
      end
      if (key_drop > 0) begin
        check("keystall_idle", 32'(idle_round), 32'd1);
        check("keystall_cc",   32'(count_cycle), 32'd1);
        check("keystall_kr",   32'(key_round), 32'd5);
        key_drop--;
      end
      if (input_round) n_inr++;
      if ((32'(input_round) + 32'(last_round) + 32'(done_round)) > 1) n_multi++;
      if (busy && idle_round) n_idle_busy++;
      if (t0 < 0 && input_round && count_cycle == 2'd0 && !idle_round) begin
        t0 = c;
        check("mode_latched", 32'(mode), 32'(m));
      end
      if (busy && !done_round && !idle_round && count_cycle == 2'd0)
        keyq.push_back(int'(key_round));
      if (last_round && count_cycle == 2'd3)
        check("mode_hold", 32'(mode), 32'(m));
      if (out_valid) begin
        n_out++;
        if (t_out < 0) t_out = c;
      end
      if (done) begin
        n_done++;
        t_done = c;
      end
      if (aborted && c == abort_c + 1)
        check_reset_outputs("abort");
      if (aborted && c >= abort_c + 8) begin
        finished = 1;
        break;
      end
      if (n_done > 0) begin
        check("idle_after_done", 32'(busy), 32'd0);
        post++;
        if (post >= 4) begin
          finished = 1;
          break;
        end
      end
    end
    start = 1'b0; abort = 1'b0;
    if (!finished) check("block_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    // Reset
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_reset_outputs("post_reset");

    // Encrypt, no stalls, with an ignored start mid-block
    run_block(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("enc_input_cycles", 32'(n_inr), 32'd4);
    check("enc_latency", 32'(t_out - t0), 32'd44);
    check("enc_done_count", 32'(n_done), 32'd1);
    check("enc_out_count", 32'(n_out), 32'd4);
    check("enc_done_time", 32'(t_done - t_out), 32'd4);
    check("enc_key_len", 32'(keyq.size()), 32'd11);
    for (int i = 0; i < keyq.size() && i < 11; i++)
      check("enc_key_seq", 32'(keyq[i]), 32'(i));
    check("enc_one_strobe", 32'(n_multi), 32'd0);
    check("enc_no_stall", 32'(n_idle_busy), 32'd0);

    // Decrypt
    run_block(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("dec_latency", 32'(t_out - t0), 32'd44);
    check("dec_key_len", 32'(keyq.size()), 32'd11);
    for (int i = 0; i < keyq.size() && i < 11; i++)
      check("dec_key_seq", 32'(keyq[i]), 32'(10 - i));
    check("dec_done_count", 32'(n_done), 32'd1);

    // Input stall of 3 at word 2, key stall of 2 at round 5 word 1
    run_block(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("stall_latency", 32'(t_out - t0), 32'd49);
    check("stall_input_cycles", 32'(n_inr), 32'd7);
    check("stall_idle_cycles", 32'(n_idle_busy), 32'd5);
    check("stall_done_count", 32'(n_done), 32'd1);
    check("stall_out_count", 32'(n_out), 32'd4);

    // Abort in round 6
    run_block(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("abort_out_count", 32'(n_out), 32'd0);
    check("abort_done_count", 32'(n_done), 32'd0);

    // Abort wins over start in the same IDLE cycle
    @(negedge clk);
    start = 1'b1; mode_in = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    #1;
    check("abort_vs_start_busy", 32'(busy), 32'd0);
    check("abort_vs_start_inr", 32'(input_round), 32'd0);

    // Async reset during LAST, then a clean block
    run_block(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run_block(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("after_rst_latency", 32'(t_out - t0), 32'd44);
    check("after_rst_done", 32'(n_done), 32'd1);
    check("after_rst_outs", 32'(n_out), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
